iq_setpoint_sequencer: RTL and testbench
========================================

IQ_SETPOINT_SEQUENCER -- requirements
Module: iq_setpoint_sequencer

Interface
REQ-001 Parameter STEP, default 16'd4: unsigned iq_aim slew per control period.
REQ-002 Parameter HOLD_PERIODS, default 16'd9000: number of control periods the target is held after it is reached.
REQ-003 Parameter LIMIT, default 16'd1000: unsigned |iq| overcurrent threshold.
REQ-004 Parameter TRIP_CNT, default 8'd16: number of consecutive over-limit periods that trips a fault.
REQ-005 clk  in  1  clock.
REQ-006 rstn  in  1  reset, asynchronous, active-low.
REQ-007 i_en_idq  in  1  one-cycle pulse marking a new control period, when i_iq is valid.
REQ-008 i_iq  in  16 signed  measured q-axis current.
REQ-009 i_tgt_valid  in  1  target offer.
REQ-010 o_tgt_ready  out  1  target accept.
REQ-011 i_tgt  in  16 signed  requested iq target.
REQ-012 o_iq_aim  out  16 signed  q-axis setpoint for the current loop.
REQ-013 o_busy  out  1  high in RAMP or HOLD.
REQ-014 i_fault_clr  in  1  fault acknowledge.
REQ-015 o_fault  out  1  latched overcurrent fault.

Function
REQ-016 The FSM SHALL have the states IDLE, RAMP, HOLD and FAULT.
REQ-017 o_tgt_ready SHALL be 1 only in IDLE; a transfer occurs when i_tgt_valid and o_tgt_ready are both 1 in the same cycle.
REQ-018 On a transfer, i_tgt SHALL be latched and the FSM SHALL enter RAMP on the next edge, so o_tgt_ready drops 1 cycle after the transfer.
REQ-019 In RAMP, on each i_en_idq pulse, the block SHALL compute d = tgt - aim in 17-bit signed arithmetic.
REQ-020 If |d| <= STEP, aim SHALL be set to tgt and the FSM SHALL enter HOLD with the hold counter loaded to HOLD_PERIODS.
REQ-021 Otherwise, aim SHALL move by +STEP or -STEP toward tgt; aim never overshoots or wraps.
REQ-022 o_iq_aim SHALL update exactly 1 clk after the qualifying i_en_idq pulse and SHALL be stable between pulses.
REQ-023 In HOLD, each i_en_idq pulse SHALL decrement the counter; the FSM SHALL enter IDLE on the edge the counter reaches 0, with aim held.
REQ-024 If HOLD_PERIODS = 0, the FSM SHALL go HOLD->IDLE on the next clk without waiting for a pulse.
REQ-025 A target equal to the current aim SHALL pass RAMP->HOLD on the first pulse.
REQ-026 i_tgt_valid outside IDLE SHALL be ignored, with no latching.
REQ-027 i_en_idq in IDLE SHALL leave aim unchanged.

Reset
REQ-028 On rstn=0, the FSM SHALL be IDLE, o_iq_aim=0, o_busy=0, o_fault=0, o_tgt_ready=1 after release, and all counters 0.
REQ-029 Reset asserted mid-RAMP or mid-HOLD SHALL abort immediately and asynchronously, forcing o_iq_aim to 0.

Configuration
REQ-030 Macro IQ_SEQ_WATCHDOG_EN SHALL compile the overcurrent watchdog in or out.
REQ-031 With the macro, each i_en_idq pulse SHALL do one of two things: increment a saturating consecutive counter when |i_iq| > LIMIT (17-bit abs, so -32768 reads as 32768), or clear the counter otherwise.
REQ-032 With the macro, when the counter reaches TRIP_CNT, from any state, the FSM SHALL enter FAULT next clk with o_iq_aim=0, o_fault=1, o_busy=0 and o_tgt_ready=0; a trip SHALL take priority over a simultaneous transfer, ramp step or hold expiry.
REQ-033 With the macro, i_fault_clr=1 in FAULT SHALL return the FSM to IDLE and clear o_fault and the counter, with aim remaining 0; i_fault_clr outside FAULT SHALL be ignored.
REQ-034 Without the macro, o_fault SHALL be constant 0, FAULT SHALL be unreachable, and i_iq and i_fault_clr SHALL be unused.

Verification
REQ-035 Ramp: STEP=4, HOLD_PERIODS=3, target +200 from 0 -> 50 pulses of +4; o_iq_aim=200 after pulse 50, HOLD for 3 pulses, then IDLE with ready=1.
REQ-036 Reverse and partial step: aim=200, target -198 -> 99 steps of -4 to -196, then a final step to -198; no overshoot.
REQ-037 Handshake: valid held high during RAMP with i_tgt changing -> only the value at the IDLE transfer is used, and ready is low for the whole sequence.
REQ-038 Hold corner: HOLD_PERIODS=0 -> IDLE 1 clk after the target is reached; a target equal to aim -> HOLD after the first pulse.
REQ-039 Watchdog (macro defined): LIMIT=1000, TRIP_CNT=16, i_iq=1001 for 15 pulses then 0 -> no trip; i_iq=-1001 for 16 pulses -> o_fault=1 and o_iq_aim=0 next clk; i_fault_clr -> IDLE.
REQ-040 Async reset mid-RAMP at aim=120 -> o_iq_aim=0 and o_busy=0 without a clock edge; macro undefined -> o_fault stays 0 with i_iq=32767.

Source files
------------

// File: rtl/iq_setpoint_sequencer.sv
// Slew-limited q-axis current setpoint sequencer: ramps o_iq_aim toward an accepted target, then holds.
// Define IQ_SEQ_WATCHDOG_EN to build in the consecutive-overcurrent watchdog and its FAULT state.
module iq_setpoint_sequencer #(
  parameter logic [15:0] STEP         = 16'd4,
  parameter logic [15:0] HOLD_PERIODS = 16'd9000,
  parameter logic [15:0] LIMIT        = 16'd1000,
  parameter logic [7:0]  TRIP_CNT     = 8'd16
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               i_en_idq,
  input  logic signed [15:0] i_iq,
  input  logic               i_tgt_valid,
  output logic               o_tgt_ready,
  input  logic signed [15:0] i_tgt,
  output logic signed [15:0] o_iq_aim,
  output logic               o_busy,
  input  logic               i_fault_clr,
  output logic               o_fault
);

  typedef enum logic [1:0] {IDLE, RAMP, HOLD, FAULT} state_t;

  state_t             state;
  logic signed [15:0] tgt;
  logic signed [15:0] aim;
  logic [15:0]        hold_cnt;
  logic               ready_q;
  logic               busy_q;
  logic               fault_q;

  // Distance to target in 17 bits so opposite-sign extremes cannot wrap.
  logic signed [16:0] diff;
  logic [16:0]        diff_abs;
  logic               step_hit;
  logic [15:0]        aim_toward;

  assign diff       = {tgt[15], tgt} - {aim[15], aim};
  assign diff_abs   = diff[16] ? (~diff + 17'sd1) : diff;
  assign step_hit   = (diff_abs <= {1'b0, STEP});
  assign aim_toward = diff[16] ? (aim - STEP) : (aim + STEP);

  logic trip;
  logic fault_clr_go;

`ifdef IQ_SEQ_WATCHDOG_EN
  logic [7:0]  wd_cnt;
  logic [16:0] iq_abs;
  logic        over_limit;

  assign iq_abs       = i_iq[15] ? (17'd0 - {i_iq[15], i_iq}) : {1'b0, i_iq};
  assign over_limit   = (iq_abs > {1'b0, LIMIT});
  assign trip         = (wd_cnt >= TRIP_CNT);
  assign fault_clr_go = (state == FAULT) && i_fault_clr;

  // Saturating run-length of consecutive over-limit periods.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wd_cnt <= 8'd0;
    end else if (fault_clr_go) begin
      wd_cnt <= 8'd0;
    end else if (i_en_idq) begin
      if (!over_limit) wd_cnt <= 8'd0;
      else if (wd_cnt != 8'hFF) wd_cnt <= wd_cnt + 8'd1;
    end
  end
`else
  logic unused_inputs;
  assign unused_inputs = ^{i_iq, i_fault_clr};
  assign trip          = 1'b0;
  assign fault_clr_go  = 1'b0;
`endif

  // A trip overrides every other transition except the acknowledge that clears it.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state    <= IDLE;
      tgt      <= '0;
      aim      <= '0;
      hold_cnt <= '0;
      ready_q  <= 1'b1;
      busy_q   <= 1'b0;
      fault_q  <= 1'b0;
    end else if (trip && !fault_clr_go) begin
      state    <= FAULT;
      aim      <= '0;
      hold_cnt <= '0;
      ready_q  <= 1'b0;
      busy_q   <= 1'b0;
      fault_q  <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (i_tgt_valid) begin
            tgt     <= i_tgt;
            state   <= RAMP;
            ready_q <= 1'b0;
            busy_q  <= 1'b1;
          end
        end
        RAMP: begin
          if (i_en_idq) begin
            if (step_hit) begin
              aim      <= tgt;
              hold_cnt <= HOLD_PERIODS;
              state    <= HOLD;
            end else begin
              aim <= aim_toward;
            end
          end
        end
        HOLD: begin
          if (hold_cnt == 16'd0 || (i_en_idq && hold_cnt == 16'd1)) begin
            hold_cnt <= 16'd0;
            state    <= IDLE;
            ready_q  <= 1'b1;
            busy_q   <= 1'b0;
          end else if (i_en_idq) begin
            hold_cnt <= hold_cnt - 16'd1;
          end
        end
        FAULT: begin
          if (fault_clr_go) begin
            state   <= IDLE;
            ready_q <= 1'b1;
            fault_q <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign o_tgt_ready = ready_q;
  assign o_busy      = busy_q;
  assign o_fault     = fault_q;
  assign o_iq_aim    = aim;

endmodule

// File: tb/tb_iq_setpoint_sequencer.sv
// Directed bench for iq_setpoint_sequencer: ramp, reverse, handshake, hold corners, watchdog, async reset.
// Expected setpoints come from a step model via a queue scoreboard.
module tb_iq_setpoint_sequencer;

  logic               clk = 1'b0;
  logic               rstn;
  logic               i_en_idq;
  logic signed [15:0] i_iq;
  logic               i_tgt_valid;
  logic               valid0;
  logic signed [15:0] i_tgt;
  logic               i_fault_clr;
  logic               o_tgt_ready, ready0;
  logic signed [15:0] o_iq_aim, aim0;
  logic               o_busy, busy0;
  logic               o_fault, fault0;

  int passCount  = 0;
  int failCount  = 0;
  int checkCount = 0;

  logic signed [15:0] expQ[$];
  int                 modelAim;

  always #5 clk = ~clk;

  iq_setpoint_sequencer #(
    .STEP(16'd4), .HOLD_PERIODS(16'd3), .LIMIT(16'd1000), .TRIP_CNT(8'd16)
  ) dut (
    .clk(clk), .rstn(rstn), .i_en_idq(i_en_idq), .i_iq(i_iq),
    .i_tgt_valid(i_tgt_valid), .o_tgt_ready(o_tgt_ready), .i_tgt(i_tgt),
    .o_iq_aim(o_iq_aim), .o_busy(o_busy), .i_fault_clr(i_fault_clr), .o_fault(o_fault)
  );

  iq_setpoint_sequencer #(
    .STEP(16'd4), .HOLD_PERIODS(16'd0), .LIMIT(16'd1000), .TRIP_CNT(8'd16)
  ) dut0 (
    .clk(clk), .rstn(rstn), .i_en_idq(i_en_idq), .i_iq(i_iq),
    .i_tgt_valid(valid0), .o_tgt_ready(ready0), .i_tgt(i_tgt),
    .o_iq_aim(aim0), .o_busy(busy0), .i_fault_clr(i_fault_clr), .o_fault(fault0)
  );

  initial begin
    #2_000_000;
    $display("[TB] FAIL timeout: observed no end of run, expected $finish");
    $fatal(1, "[TB] timeout");
  end

  function automatic int modelStep(input int tgt, input int aim);
    int d;
    d = tgt - aim;
    if (d >= -4 && d <= 4) return tgt;
    else if (d > 0) return aim + 4;
    else return aim - 4;
  endfunction

  task automatic checkOutput(input string tag, input logic signed [31:0] obs,
                             input logic signed [31:0] exp);
    checkCount++;
    assert (obs === exp) passCount++;
    else begin
      failCount++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Called at a negedge; the pulse is sampled on the next posedge and the bench returns at the following negedge.
  task automatic applyStimulus(input logic en, input logic signed [15:0] iq);
    i_en_idq = en;
    i_iq     = iq;
    @(negedge clk);
    i_en_idq = 1'b0;
  endtask

  task automatic rampPulse(input int tgt);
    modelAim = modelStep(tgt, modelAim);
    expQ.push_back(16'(modelAim));
    applyStimulus(1'b1, 16'sd0);
    checkOutput("aim_step", o_iq_aim, expQ.pop_front());
  endtask

  initial begin
    rstn = 1'b0; i_en_idq = 1'b0; i_iq = '0; i_tgt_valid = 1'b0;
    valid0 = 1'b0; i_tgt = '0; i_fault_clr = 1'b0;
    @(negedge clk);
    checkOutput("rst_aim", o_iq_aim, 0);
    checkOutput("rst_busy", o_busy, 0);
    checkOutput("rst_fault", o_fault, 0);
    rstn = 1'b1;
    @(negedge clk);
    checkOutput("rst_ready", o_tgt_ready, 1);
    checkOutput("rst_ready0", ready0, 1);

    // Ramp to +200 with valid held high and i_tgt wandering; only the IDLE value counts.
    i_tgt = 16'sd200; i_tgt_valid = 1'b1;
    @(negedge clk);
    checkOutput("xfer_ready", o_tgt_ready, 0);
    checkOutput("xfer_busy", o_busy, 1);
    modelAim = 0;
    for (int i = 1; i <= 50; i++) begin
      i_tgt = 16'($urandom);
      rampPulse(200);
      checkOutput("ramp_ready", o_tgt_ready, 0);
      if (i == 10) begin
        @(negedge clk);
        checkOutput("aim_stable", o_iq_aim, 40);
      end
    end
    checkOutput("aim_200", o_iq_aim, 200);
    i_tgt_valid = 1'b0;
    applyStimulus(1'b1, 16'sd0);
    checkOutput("hold1_busy", o_busy, 1);
    applyStimulus(1'b1, 16'sd0);
    checkOutput("hold2_ready", o_tgt_ready, 0);
    applyStimulus(1'b1, 16'sd0);
    checkOutput("hold3_busy", o_busy, 0);
    checkOutput("hold3_ready", o_tgt_ready, 1);
    checkOutput("hold3_aim", o_iq_aim, 200);

    // Reverse ramp ending with a partial step.
    i_tgt = -16'sd198; i_tgt_valid = 1'b1;
    @(negedge clk);
    i_tgt_valid = 1'b0;
    checkOutput("rev_ready", o_tgt_ready, 0);
    for (int i = 1; i <= 100; i++) begin
      rampPulse(-198);
      if (i == 99) checkOutput("rev_99", o_iq_aim, -196);
    end
    checkOutput("rev_final", o_iq_aim, -198);
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 16'sd0);
    checkOutput("rev_idle", o_busy, 0);

    applyStimulus(1'b1, 16'sd0);
    checkOutput("idle_pulse_aim", o_iq_aim, -198);

    // Target equal to aim reaches HOLD on the first pulse.
    i_tgt_valid = 1'b1;
    @(negedge clk);
    i_tgt_valid = 1'b0;
    applyStimulus(1'b1, 16'sd0);
    checkOutput("eq_aim", o_iq_aim, -198);
    checkOutput("eq_busy", o_busy, 1);
    applyStimulus(1'b1, 16'sd0);
    applyStimulus(1'b1, 16'sd0);
    checkOutput("eq_hold2", o_busy, 1);
    applyStimulus(1'b1, 16'sd0);
    checkOutput("eq_idle", o_busy, 0);

    // Zero-length hold: back to IDLE one clk after the target is reached.
    i_tgt = 16'sd8; valid0 = 1'b1;
    @(negedge clk);
    valid0 = 1'b0;
    checkOutput("h0_ready", ready0, 0);
    applyStimulus(1'b1, 16'sd0);
    checkOutput("h0_aim4", aim0, 4);
    applyStimulus(1'b1, 16'sd0);
    checkOutput("h0_aim8", aim0, 8);
    checkOutput("h0_busy_hold", busy0, 1);
    @(negedge clk);
    checkOutput("h0_busy_idle", busy0, 0);
    checkOutput("h0_ready_idle", ready0, 1);

`ifdef IQ_SEQ_WATCHDOG_EN
    for (int i = 0; i < 15; i++) applyStimulus(1'b1, 16'sd1001);
    applyStimulus(1'b1, 16'sd0);
    @(negedge clk);
    checkOutput("wd_no_trip", o_fault, 0);
    for (int i = 0; i < 16; i++) applyStimulus(1'b1, -16'sd1001);
    @(negedge clk);
    checkOutput("wd_fault", o_fault, 1);
    checkOutput("wd_aim", o_iq_aim, 0);
    checkOutput("wd_busy", o_busy, 0);
    checkOutput("wd_ready", o_tgt_ready, 0);
    i_fault_clr = 1'b1;
    @(negedge clk);
    i_fault_clr = 1'b0;
    checkOutput("clr_fault", o_fault, 0);
    checkOutput("clr_ready", o_tgt_ready, 1);
    checkOutput("clr_aim", o_iq_aim, 0);
`else
    for (int i = 0; i < 20; i++) applyStimulus(1'b1, 16'sd32767);
    checkOutput("nowd_fault", o_fault, 0);
    checkOutput("nowd_ready", o_tgt_ready, 1);
    i_fault_clr = 1'b1;
    @(negedge clk);
    i_fault_clr = 1'b0;
    checkOutput("nowd_fault_clr", o_fault, 0);
`endif

    // Restart from zero, ramp to 120, then reset between clock edges.
    rstn = 1'b0;
    #1 rstn = 1'b1;
    @(negedge clk);
    i_tgt = 16'sd400; i_tgt_valid = 1'b1;
    @(negedge clk);
    i_tgt_valid = 1'b0;
    modelAim = 0;
    for (int i = 0; i < 30; i++) rampPulse(400);
    checkOutput("pre_rst_aim", o_iq_aim, 120);
    #2 rstn = 1'b0;
    #1;
    checkOutput("async_aim", o_iq_aim, 0);
    checkOutput("async_busy", o_busy, 0);
    checkOutput("async_fault", o_fault, 0);
    @(negedge clk);
    rstn = 1'b1;

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
